// File: rtl/seq_mul_param.sv
// Radix-2 shift-add sequential multiplier, WIDTH-bit operands, runtime signed/unsigned.
// Optional SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start; op holds the last product
// RUN   | one shift-add step per clock on operand magnitudes
module seq_mul_param #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   op
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state, state_nxt;
   logic                 load, last;
   logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
   logic [WIDTH-1:0]     mplier, mplier_sh, mag_a, mag_b;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 neg;

   // Magnitudes stay exact for the most negative value since they are read as unsigned.
   always_comb begin
      mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
      acc_nxt   = acc + (mplier[0] ? mcand : '0);
      mplier_sh = mplier >> 1;
      cnt_nxt   = cnt + CW'(1);
`ifdef SEQ_MUL_EARLY_TERM_EN
      last      = (cnt_nxt == CNT_LAST) || (mplier_sh == '0);
`else
      last      = (cnt_nxt == CNT_LAST);
`endif
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         done   <= 1'b0;
         op     <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if (load) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            cnt    <= cnt_nxt;
            if (last) begin
               op   <= neg ? -acc_nxt : acc_nxt;
               done <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param: directed cases plus random operands against
// an arithmetic reference model (product via integer multiply, latency via bit length).
module tb_seq_mul_param;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst, start, sgn;
   logic [W-1:0]   a, b;
   logic           busy, done;
   logic [2*W-1:0] op;

   int checks = 0;
   int errors = 0;

   seq_mul_param #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn),
      .a(a), .b(b), .busy(busy), .done(done), .op(op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
      longint xv, yv, p;
      xv = s ? longint'($signed(x)) : longint'(x);
      yv = s ? longint'($signed(y)) : longint'(y);
      p  = xv * yv;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_lat(input logic s, input logic [W-1:0] y);
`ifdef SEQ_MUL_EARLY_TERM_EN
      int mag, hb;
      mag = (s && y[W-1]) ? -int'($signed(y)) : int'(y);
      hb  = 0;
      for (int i = 0; i < W; i++)
         if (mag[i]) hb = i + 1;
      return (hb == 0) ? 1 : hb;
`else
      return W;
`endif
   endfunction

   // One multiply from an idle DUT; optional start with 0xFF operands mid-run to be ignored.
   task automatic do_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit poke);
      int n;
      bit got;
      logic [2*W-1:0] exp_op;
      exp_op = ref_prod(s, x, y);
      @(negedge clk);
      sgn = s; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
      chk("busy_after_start", busy, 1'b1);
      n = 0; got = 0;
      while (n < 40 && !got) begin
         if (poke && n == 2) begin
            start = 1'b1; a = '1; b = '1; sgn = 1'b0;
         end
         @(posedge clk); #1;
         if (poke) start = 1'b0;
         n++;
         if (done) got = 1;
         else if (busy !== 1'b1) chk("busy_during_run", busy, 1'b1);
      end
      chk("completed", got, 1'b1);
      chk("latency", n, ref_lat(s, y));
      chk("product", op, exp_op);
      chk("busy_at_done", busy, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("done_single", done, 1'b0);
      end
      chk("op_held", op, exp_op);
   endtask

   task automatic held_start();
      logic [W-1:0] xs[3] = '{8'h02, 8'h10, 8'h00};
      logic [W-1:0] ys[3] = '{8'h03, 8'h10, 8'h9C};
      int idx, cyc, prev, gap;
      @(negedge clk);
      sgn = 1'b0; a = xs[0]; b = ys[0]; start = 1'b1;
      @(posedge clk); #1;
      idx = 0; cyc = 0; prev = 0;
      while (idx < 3 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            gap = ref_lat(1'b0, ys[idx]) + ((idx == 0) ? 0 : 1);
            chk("held_product", op, ref_prod(1'b0, xs[idx], ys[idx]));
            chk("held_gap", cyc - prev, gap);
            prev = cyc;
            idx++;
            if (idx < 3) begin
               a = xs[idx]; b = ys[idx];
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("held_count", idx, 3);
   endtask

   task automatic reset_mid_run();
      int seen;
      @(negedge clk);
      sgn = 1'b0; a = 8'h33; b = 8'hF1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_op", op, '0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("rst_no_done", seen, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_op", op, '0);
      rst = 1'b0;

      do_mul(1'b0, 8'h5D, 8'hB5, 0);
      chk("tp1_value", op, 16'h41C1);
      do_mul(1'b1, 8'h5D, 8'hB5, 0);
      chk("tp2_value", op, 16'hE4C1);
      do_mul(1'b1, 8'h80, 8'h80, 0);
      do_mul(1'b0, 8'hFF, 8'hFF, 0);
      do_mul(1'b0, 8'h03, 8'h05, 1);
      chk("ignored_start", op, 16'h000F);

      reset_mid_run();
      do_mul(1'b0, 8'h07, 8'h06, 0);

      held_start();

      do_mul(1'b0, 8'hA7, 8'h03, 0);
      do_mul(1'b0, 8'hA7, 8'h00, 0);
      do_mul(1'b0, 8'h11, 8'h80, 0);
      do_mul(1'b1, 8'h7F, 8'h81, 0);

      for (int i = 0; i < 25; i++)
         do_mul(1'($urandom), W'($urandom), W'($urandom), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
